// File: rtl/fifo_read_ctrl_if.sv
// Read-side port bundle of the asynchronous FIFO.
// The slave modport is the read controller; the master modport is its environment.
interface fifo_read_ctrl_if #(
    parameter int addr_size  = 4,
    parameter int word_width = 8
);
    logic                  rd_en;
    logic [addr_size:0]    wptr_gray;
    logic [word_width-1:0] data_r;
    logic [addr_size-1:0]  addr_r;
    logic [addr_size:0]    rptr_gray;
    logic [word_width-1:0] dout;
    logic                  dout_valid;
    logic                  empty;
    logic                  almost_empty;
    logic [addr_size:0]    rd_level;
    logic                  underflow;

    modport slave (
        input  rd_en, wptr_gray, data_r,
        output addr_r, rptr_gray, dout, dout_valid, empty, almost_empty, rd_level, underflow
    );

    modport master (
        output rd_en, wptr_gray, data_r,
        input  addr_r, rptr_gray, dout, dout_valid, empty, almost_empty, rd_level, underflow
    );
endinterface

// File: rtl/fifo_read_ctrl.sv
// Read-domain controller of the asynchronous FIFO: read pointer, pessimistic
// empty/level status from a synchronized write pointer, and registered read data.
module fifo_read_ctrl #(
    parameter int addr_size  = 4,
    parameter int word_width = 8,
    parameter int ae_thresh  = 2
) (
    input  logic            clk,
    input  logic            rst,
    fifo_read_ctrl_if.slave bus
);
    localparam int ptr_w = addr_size + 1;

    function automatic logic [ptr_w-1:0] gray_to_bin(input logic [ptr_w-1:0] g);
        logic [ptr_w-1:0] b;
        b = g;
        for (int i = 1; i < ptr_w; i++) b = b ^ (g >> i);
        return b;
    endfunction

    logic [ptr_w-1:0]      r_wq1;
    logic [ptr_w-1:0]      r_wq2;
    logic [ptr_w-1:0]      r_rbin;
    logic [ptr_w-1:0]      r_rptr_gray;
    logic                  r_empty;
    logic                  r_almost_empty;
    logic [ptr_w-1:0]      r_rd_level;
    logic [word_width-1:0] r_dout;
    logic                  r_dout_valid;
    logic                  r_underflow;

    logic                  w_rd_fire;
    logic [ptr_w-1:0]      w_wbin_s;
    logic [ptr_w-1:0]      w_rbin_next;
    logic [ptr_w-1:0]      w_rgray_next;
    logic [ptr_w-1:0]      w_level_next;

    // Status is computed from the post-read pointer so a read updates empty/level on the same edge.
    assign w_rd_fire    = bus.rd_en & ~r_empty;
    assign w_wbin_s     = gray_to_bin(r_wq2);
    assign w_rbin_next  = r_rbin + ptr_w'(w_rd_fire);
    assign w_rgray_next = w_rbin_next ^ (w_rbin_next >> 1);
    assign w_level_next = w_wbin_s - w_rbin_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wq1          <= '0;
            r_wq2          <= '0;
            r_rbin         <= '0;
            r_rptr_gray    <= '0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_rd_level     <= '0;
            r_dout         <= '0;
            r_dout_valid   <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so r_wq2 takes the old r_wq1, giving a true two-flop synchronizer.
            r_wq1          <= bus.wptr_gray;
            r_wq2          <= r_wq1;
            r_rbin         <= w_rbin_next;
            r_rptr_gray    <= w_rgray_next;
            r_empty        <= (w_rgray_next == r_wq2);
            r_rd_level     <= w_level_next;
            r_almost_empty <= (w_level_next <= ptr_w'(ae_thresh));
            r_dout_valid   <= w_rd_fire;
            r_underflow    <= bus.rd_en & r_empty;
            if (w_rd_fire) r_dout <= bus.data_r;
        end
    end

    // Address comes straight from the pointer register: no combinational path from rd_en.
    assign bus.addr_r       = r_rbin[addr_size-1:0];
    assign bus.rptr_gray    = r_rptr_gray;
    assign bus.empty        = r_empty;
    assign bus.almost_empty = r_almost_empty;
    assign bus.rd_level     = r_rd_level;
    assign bus.dout         = r_dout;
    assign bus.dout_valid   = r_dout_valid;
    assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed self-checking bench for fifo_read_ctrl (addr_size=4, word_width=8, ae_thresh=2).
module tb_fifo_read_ctrl;
    logic clk;
    logic rst;
    logic mem_mode;
    logic [7:0] data_drv;
    int n_cmp;
    int n_err;

    fifo_read_ctrl_if #(.addr_size(4), .word_width(8)) bus ();

    fifo_read_ctrl #(.addr_size(4), .word_width(8), .ae_thresh(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Memory model: either a fixed word, or the address itself as data.
    assign bus.data_r = mem_mode ? {4'h0, bus.addr_r} : data_drv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_empty"}, 32'(bus.empty), 1);
        check({tag, "_ae"}, 32'(bus.almost_empty), 1);
        check({tag, "_rptr"}, 32'(bus.rptr_gray), 0);
        check({tag, "_addr"}, 32'(bus.addr_r), 0);
        check({tag, "_dout"}, 32'(bus.dout), 0);
        check({tag, "_valid"}, 32'(bus.dout_valid), 0);
        check({tag, "_level"}, 32'(bus.rd_level), 0);
        check({tag, "_uflow"}, 32'(bus.underflow), 0);
    endtask

    // Drain 16 words starting at read pointer rb; data equals address.
    task automatic drain16(input string tag, inout logic [4:0] rb);
        logic [4:0] prev;
        bus.rd_en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            prev = bus.rptr_gray;
            tick();
            check({tag, "_dout"}, 32'(bus.dout), 32'(rb[3:0]));
            check({tag, "_valid"}, 32'(bus.dout_valid), 1);
            rb = rb + 5'd1;
            check({tag, "_addr"}, 32'(bus.addr_r), 32'(rb[3:0]));
            check({tag, "_rptr"}, 32'(bus.rptr_gray), 32'(gray(rb)));
            check({tag, "_gray_step"}, 32'($countones(prev ^ bus.rptr_gray)), 1);
            check({tag, "_level"}, 32'(bus.rd_level), 32'(16 - k));
            check({tag, "_ae"}, 32'(bus.almost_empty), 32'((16 - k) <= 2));
            check({tag, "_empty"}, 32'(bus.empty), 32'(k == 16));
        end
        bus.rd_en = 1'b0;
        tick();
        check({tag, "_valid_end"}, 32'(bus.dout_valid), 0);
        check({tag, "_uflow_end"}, 32'(bus.underflow), 0);
    endtask

    initial begin
        logic [4:0] rb;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        mem_mode = 1'b0;
        data_drv = 8'h00;
        bus.rd_en = 1'b0;
        bus.wptr_gray = 5'b00000;

        // 1: asynchronous reset asserted mid-cycle, checked before any edge
        tick();
        tick();
        #3;
        rst = 1'b1;
        #1;
        check_reset("t1");
        tick();
        #3;
        rst = 1'b0;

        // 2: one word written; visible after 3 edges, then read once
        bus.wptr_gray = 5'b00001;
        tick();
        tick();
        check("t2_empty_e2", 32'(bus.empty), 1);
        tick();
        check("t2_empty_e3", 32'(bus.empty), 0);
        check("t2_level_e3", 32'(bus.rd_level), 1);
        check("t2_ae_e3", 32'(bus.almost_empty), 1);
        data_drv = 8'hA5;
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        check("t2_dout", 32'(bus.dout), 32'hA5);
        check("t2_valid", 32'(bus.dout_valid), 1);
        check("t2_addr", 32'(bus.addr_r), 1);
        check("t2_rptr", 32'(bus.rptr_gray), 1);
        check("t2_empty", 32'(bus.empty), 1);
        check("t2_level", 32'(bus.rd_level), 0);
        tick();
        check("t2_valid_drop", 32'(bus.dout_valid), 0);

        // 3: reads while empty only raise underflow
        data_drv = 8'h3C;
        bus.rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_uflow", 32'(bus.underflow), 1);
            check("t3_valid", 32'(bus.dout_valid), 0);
            check("t3_addr", 32'(bus.addr_r), 1);
            check("t3_rptr", 32'(bus.rptr_gray), 1);
            check("t3_dout", 32'(bus.dout), 32'hA5);
        end
        bus.rd_en = 1'b0;
        tick();
        check("t3_uflow_drop", 32'(bus.underflow), 0);

        // 4: fresh pointers, full FIFO of 16 drained back to back
        #3;
        rst = 1'b1;
        #1;
        check_reset("t4_rst");
        #1;
        rst = 1'b0;
        mem_mode = 1'b1;
        bus.wptr_gray = 5'b11000;
        tick();
        tick();
        tick();
        check("t4_level", 32'(bus.rd_level), 16);
        check("t4_ae", 32'(bus.almost_empty), 0);
        check("t4_empty", 32'(bus.empty), 0);
        rb = 5'd0;
        drain16("t4", rb);
        check("t4_rptr_final", 32'(bus.rptr_gray), 32'h18);

        // 5: two more fill/drain rounds, pointer wraps 31 -> 0
        for (int r = 0; r < 2; r++) begin
            bus.wptr_gray = gray(rb + 5'd16);
            tick();
            tick();
            tick();
            check("t5_level", 32'(bus.rd_level), 16);
            drain16("t5", rb);
        end
        check("t5_rptr_final", 32'(bus.rptr_gray), 32'h18);

        // 6: reset in the middle of a burst with 8 words available
        bus.wptr_gray = gray(rb + 5'd8);
        tick();
        tick();
        tick();
        check("t6_level", 32'(bus.rd_level), 8);
        bus.rd_en = 1'b1;
        tick();
        tick();
        check("t6_level_mid", 32'(bus.rd_level), 6);
        #3;
        rst = 1'b1;
        bus.wptr_gray = 5'b00000;
        #1;
        check_reset("t6_rst");
        tick();
        #3;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_empty", 32'(bus.empty), 1);
            check("t6_uflow", 32'(bus.underflow), 1);
            check("t6_valid", 32'(bus.dout_valid), 0);
            check("t6_rptr", 32'(bus.rptr_gray), 0);
            check("t6_addr", 32'(bus.addr_r), 0);
        end
        bus.rd_en = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fifo_read_ctrl.md
Name: fifo_read_ctrl

Overview:
Read-side controller of the asynchronous FIFO, operating entirely in the read clock domain. It owns the read pointer and computes the empty, almost-empty and level status from a synchronized copy of the write pointer. It drives the read address of the FIFO register memory, which has an asynchronous read port. It registers the returned word, and exports a Gray-coded read pointer back to the write domain.

Parameters:
addr_size, 4, memory address width; FIFO depth = 2**addr_size
word_width, 8, data word width
ae_thresh, 2, almost_empty asserts when level <= ae_thresh (range 0..2**addr_size)

Ports:
clk  input  1  read-domain clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
rd_en  input  1  read request from consumer
wptr_gray  input  addr_size+1  Gray write pointer from write domain (asynchronous to clk)
data_r  input  word_width  word returned combinationally by memory at addr_r
addr_r  output  addr_size  read address to memory
rptr_gray  output  addr_size+1  registered Gray read pointer, to write-domain synchronizer
dout  output  word_width  registered read data
dout_valid  output  1  one-cycle pulse, dout holds a newly read word
empty  output  1  FIFO empty (registered)
almost_empty  output  1  level <= ae_thresh (registered)
rd_level  output  addr_size+1  words available, 0..2**addr_size (registered, pessimistic)
underflow  output  1  one-cycle pulse: rd_en while empty

Behaviour:
- Reset (async assert, all regs): rbin=0, rptr_gray=0, sync flops=0, empty=1, almost_empty=1, rd_level=0, dout=0, dout_valid=0, underflow=0.
- Synchronizer: wq1<=wptr_gray, wq2<=wq1. No other logic touches wptr_gray. wbin_s = Gray-to-binary(wq2).
- rd_fire = rd_en & ~empty. Reads are never accepted while empty.
- rbin_next = rbin + rd_fire, with natural wrap modulo 2**(addr_size+1). rgray_next = rbin_next ^ (rbin_next>>1).
- Each edge: rbin<=rbin_next, rptr_gray<=rgray_next, empty<=(rgray_next==wq2).
- Each edge: rd_level<=(wbin_s - rbin_next) mod 2**(addr_size+1). almost_empty<=(that value <= ae_thresh).
- addr_r = rbin[addr_size-1:0], taken from the register with no combinational path from rd_en. Address wraps from 2**addr_size-1 to 0.
- Data latency: on a rd_fire edge, dout<=data_r (word at the pre-increment addr_r) and dout_valid<=1. Otherwise dout holds and dout_valid<=0.
- underflow<=rd_en & empty, one pulse per offending cycle. Pointers and dout are unchanged.
- Status is pessimistic: a write becomes visible after 2 sync edges plus 1 status edge. empty deasserts on the 3rd rising clk after wptr_gray changes. A read updates empty/level on the same edge.
- Simultaneous read and write-pointer change: the read is evaluated against the old wq2. The new write is counted once it is synchronized. No word is lost or duplicated.
- rptr_gray changes by at most one bit per clk. It comes straight from a flop, with no glitching logic.
- Reset mid-operation: all outputs return to reset values immediately, independent of clk. Any in-flight read is discarded.
- rd_level never exceeds 2**addr_size when the write side honours full. Overflowed write pointers are outside this block's scope.

Test Plan:
(Test plan uses addr_size=4, word_width=8, ae_thresh=2.)
1. Assert rst asynchronously mid-cycle -> immediately empty=1, almost_empty=1, rptr_gray=0, addr_r=0, dout=0, dout_valid=0, rd_level=0, underflow=0.
2. After reset, set wptr_gray=5'b00001 -> empty=0 and rd_level=1 after the 3rd rising edge. Then rd_en=1 for one cycle with data_r=8'hA5 -> next edge: dout=8'hA5, dout_valid=1 for one cycle, addr_r=1, rptr_gray=5'b00001, empty=1, rd_level=0.
3. With empty=1, hold rd_en=1 for 3 cycles -> underflow high for 3 cycles. dout_valid=0; addr_r, rptr_gray and dout unchanged.
4. Set wptr_gray=gray(16)=5'b11000 -> rd_level=16, almost_empty=0. Do 16 back-to-back reads with data_r=addr -> dout sequence 0..15, and addr_r wraps 15->0. almost_empty rises when rd_level reaches 2. empty=1 after the 16th read, rptr_gray=5'b11000.
5. Pointer wrap: fill and drain twice more (32 total reads) -> rptr_gray steps 5'b10000 (gray 31) to 5'b00000 with a single-bit change. Check every rptr_gray transition is single-bit, and rd_level stays correct across the wrap.
6. Assert rst during a burst of reads with rd_level=8 -> all outputs at reset values. After release with wptr_gray=0, empty stays 1 and rd_en produces only underflow.
